// File: rtl/axi_decerr_slv_pkg.sv
// axi_decerr_slv_pkg: AXI channel types, response codes and SoC constants
// shared by the error slave, its read-burst generator and its bus interface.
package axi_decerr_slv_pkg;

  localparam int unsigned IdWidthSlave = 5;
  localparam int unsigned AddrWidth    = 64;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned StrbWidth    = DataWidth / 8;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Recognisable pattern returned on every read of unmapped space.
  localparam logic [63:0] ErrSlvRespData = 64'hCA11_AB1E_BADC_AB1E;

  typedef logic [IdWidthSlave-1:0] id_t;
  typedef logic [AddrWidth-1:0]    addr_t;
  typedef logic [DataWidth-1:0]    data_t;
  typedef logic [StrbWidth-1:0]    strb_t;
  typedef logic [7:0]              len_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;

  // Number of address handshakes (0, 1 or 2) completing in one cycle.
  function automatic logic [1:0] hsCount(input logic awHs, input logic arHs);
    return {1'b0, awHs} + {1'b0, arHs};
  endfunction

endpackage

// File: rtl/axi_decerr_slv_if.sv
// axi_decerr_slv_if: request/response bundle of the crossbar's default port.
interface axi_decerr_slv_if;
  import axi_decerr_slv_pkg::*;

  req_slv_t  req;
  resp_slv_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/axi_decerr_slv_rd.sv
// axi_decerr_rd: read-burst generator of the error slave. Accepts one AR,
// then returns len+1 DECERR beats carrying a fixed data pattern.
module axi_decerr_rd
  import axi_decerr_slv_pkg::*;
#(
  parameter logic [63:0] RespData = ErrSlvRespData
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  ar_chan_t ar_i,
  input  logic     ar_valid_i,
  input  logic     r_ready_i,
  output logic     ar_ready_o,
  output logic     r_valid_o,
  output r_chan_t  r_o
);

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  rd_state_e state_q;
  len_t      beatCnt_q;
  r_chan_t   r_q;
  logic      unusedAr;

  // Read FSM: capture AR, count beats down to zero, hold the R beat while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= R_IDLE;
      beatCnt_q <= '0;
      r_q       <= '0;
    end else begin
      unique case (state_q)
        R_IDLE: begin
          if (ar_valid_i) begin
            state_q   <= R_DATA;
            beatCnt_q <= ar_i.len;
            r_q       <= '{id: ar_i.id, data: RespData, resp: RESP_DECERR,
                           last: (ar_i.len == 8'd0)};
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (beatCnt_q == 8'd0) begin
              state_q <= R_IDLE;
              r_q     <= '0;
            end else begin
              beatCnt_q <= beatCnt_q - 8'd1;
              r_q.last  <= (beatCnt_q == 8'd1);
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign ar_ready_o = (state_q == R_IDLE);
  assign r_valid_o  = (state_q == R_DATA);
  assign r_o        = r_q;

  // Address, size and burst type never influence the beat count.
  assign unusedAr = ^{ar_i.addr, ar_i.size, ar_i.burst};

endmodule

// File: rtl/axi_decerr_slv.sv
// axi_decerr_slv: default-port error slave. Completes every write and read
// burst with DECERR and logs the most recent offending address.
module axi_decerr_slv
  import axi_decerr_slv_pkg::*;
#(
  parameter logic [63:0] RespData = ErrSlvRespData,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_decerr_slv_if.slave     axi,
  output logic [63:0]         err_addr_o,
  output logic                err_is_wr_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  wr_state_e           wState_q;
  b_chan_t             b_q;
  logic                awReady, wReady, bValid;
  logic                arReady, rValid;
  r_chan_t             rBeat;
  logic                awHs, arHs;
  logic [63:0]         errAddr_q, errAddr_d;
  logic                errIsWr_q, errIsWr_d;
  logic [CntWidth-1:0] errCnt_q, errCnt_d;
  logic [CntWidth:0]   cntSum;
  logic                unusedBits;

  // Write FSM: take AW, swallow W beats until last, then hold a DECERR B
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wState_q <= W_IDLE;
      b_q      <= '0;
    end else begin
      unique case (wState_q)
        W_IDLE: begin
          if (axi.req.aw_valid) begin
            wState_q <= W_DATA;
            b_q      <= '{id: axi.req.aw.id, resp: RESP_DECERR};
          end
        end
        W_DATA: begin
          if (axi.req.w_valid && axi.req.w.last) begin
            wState_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi.req.b_ready) begin
            wState_q <= W_IDLE;
            b_q      <= '0;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  assign awReady = (wState_q == W_IDLE);
  assign wReady  = (wState_q == W_DATA);
  assign bValid  = (wState_q == W_RESP);

  axi_decerr_rd #(
    .RespData(RespData)
  ) u_rd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ar_i      (axi.req.ar),
    .ar_valid_i(axi.req.ar_valid),
    .r_ready_i (axi.req.r_ready),
    .ar_ready_o(arReady),
    .r_valid_o (rValid),
    .r_o       (rBeat)
  );

  assign awHs = axi.req.aw_valid & awReady;
  assign arHs = axi.req.ar_valid & arReady;

  // Next log state: reads win a same-cycle tie, counter saturates at all-ones
  always_comb begin
    errAddr_d = errAddr_q;
    errIsWr_d = errIsWr_q;
    if (arHs) begin
      errAddr_d = axi.req.ar.addr;
      errIsWr_d = 1'b0;
    end else if (awHs) begin
      errAddr_d = axi.req.aw.addr;
      errIsWr_d = 1'b1;
    end
    cntSum   = {1'b0, errCnt_q} + {{(CntWidth-1){1'b0}}, hsCount(awHs, arHs)};
    errCnt_d = cntSum[CntWidth] ? '1 : cntSum[CntWidth-1:0];
  end

  // Error log registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errAddr_q <= '0;
      errIsWr_q <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      errAddr_q <= errAddr_d;
      errIsWr_q <= errIsWr_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign axi.resp = '{aw_ready: awReady, ar_ready: arReady, w_ready: wReady,
                      b_valid: bValid, b: b_q, r_valid: rValid, r: rBeat};

  assign err_addr_o  = errAddr_q;
  assign err_is_wr_o = errIsWr_q;
  assign err_cnt_o   = errCnt_q;

  // Write payload, burst shape and atomic opcode are deliberately discarded.
  assign unusedBits = ^{axi.req.aw.len, axi.req.aw.size, axi.req.aw.burst,
                        axi.req.aw.atop, axi.req.w.data, axi.req.w.strb};

endmodule

// File: tb/tb_axi_decerr_slv.sv
// tb_axi_decerr_slv: directed bench for the error slave. Expected B and R
// responses are queued as stimulus is issued; a monitor pops and compares.
module tb_axi_decerr_slv;
  import axi_decerr_slv_pkg::*;

  localparam int          CntW    = 3;
  localparam logic [63:0] ExpData = 64'hCA11_AB1E_BADC_AB1E;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [63:0]     errAddr;
  logic            errIsWr;
  logic [CntW-1:0] errCnt;

  int checks   = 0;
  int failures = 0;
  int bHs      = 0;
  int rHs      = 0;

  b_chan_t expB[$];
  r_chan_t expR[$];

  axi_decerr_slv_if bus();

  axi_decerr_slv #(
    .CntWidth(CntW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi        (bus),
    .err_addr_o (errAddr),
    .err_is_wr_o(errIsWr),
    .err_cnt_o  (errCnt)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    bus.req = '0;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushRead(input id_t id, input int len);
    for (int i = 0; i <= len; i++) begin
      expR.push_back('{id: id, data: ExpData, resp: 2'b11, last: (i == len)});
    end
  endtask

  task automatic waitReadDone(input int budget);
    int n;
    n = 0;
    while (bus.resp.r_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput("readDoneInBudget", bus.resp.r_valid, 1'b0);
  endtask

  // Monitor: compare every presented B/R against the queue head; pop on handshake
  initial begin
    b_chan_t gotB;
    r_chan_t gotR;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.resp.b_valid) begin
          gotB = bus.resp.b;
          checks++;
          if (expB.size() == 0) begin
            failures++;
            $display("[TB] FAIL bUnexpected: got id=%0h resp=%0h expected no B", gotB.id, gotB.resp);
          end else begin
            if (gotB !== expB[0]) begin
              failures++;
              $display("[TB] FAIL bBeat: got id=%0h resp=%0h expected id=%0h resp=%0h",
                       gotB.id, gotB.resp, expB[0].id, expB[0].resp);
            end
            if (bus.req.b_ready) begin
              void'(expB.pop_front());
              bHs++;
            end
          end
        end
        if (bus.resp.r_valid) begin
          gotR = bus.resp.r;
          checks++;
          if (expR.size() == 0) begin
            failures++;
            $display("[TB] FAIL rUnexpected: got id=%0h last=%0b expected no R", gotR.id, gotR.last);
          end else begin
            if (gotR !== expR[0]) begin
              failures++;
              $display("[TB] FAIL rBeat: got id=%0h data=%0h resp=%0h last=%0b expected id=%0h data=%0h resp=%0h last=%0b",
                       gotR.id, gotR.data, gotR.resp, gotR.last,
                       expR[0].id, expR[0].data, expR[0].resp, expR[0].last);
            end
            if (bus.req.r_ready) begin
              void'(expR.pop_front());
              rHs++;
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int rStart;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    checkOutput("rstAwReady", bus.resp.aw_ready, 1'b1);
    checkOutput("rstArReady", bus.resp.ar_ready, 1'b1);
    checkOutput("rstWReady", bus.resp.w_ready, 1'b0);
    checkOutput("rstBValid", bus.resp.b_valid, 1'b0);
    checkOutput("rstRValid", bus.resp.r_valid, 1'b0);
    checkOutput("rstBPayload", bus.resp.b, '0);
    checkOutput("rstRData", bus.resp.r.data, '0);
    checkOutput("rstErrAddr", errAddr, '0);
    checkOutput("rstErrIsWr", errIsWr, 1'b0);
    checkOutput("rstErrCnt", errCnt, '0);
    rst = 1'b0;
    tick();

    // Single write
    bus.req.aw       = '{id: 5'h13, addr: 64'h6000_0000, len: 8'd0, size: 3'd3, burst: 2'b01, atop: 6'd0};
    bus.req.aw_valid = 1'b1;
    bus.req.b_ready  = 1'b1;
    expB.push_back('{id: 5'h13, resp: 2'b11});
    tick();
    bus.req.aw_valid = 1'b0;
    checkOutput("wrAwReadyLow", bus.resp.aw_ready, 1'b0);
    checkOutput("wrWReady", bus.resp.w_ready, 1'b1);
    checkOutput("wrErrAddr", errAddr, 64'h6000_0000);
    checkOutput("wrErrIsWr", errIsWr, 1'b1);
    checkOutput("wrErrCnt", errCnt, 3'd1);
    bus.req.w       = '{data: 64'h1234, strb: 8'hFF, last: 1'b1};
    bus.req.w_valid = 1'b1;
    tick();
    bus.req.w_valid = 1'b0;
    checkOutput("wrBValid", bus.resp.b_valid, 1'b1);
    checkOutput("wrWReadyLow", bus.resp.w_ready, 1'b0);
    tick();
    checkOutput("wrAwReadyBack", bus.resp.aw_ready, 1'b1);
    checkOutput("wrBDone", bus.resp.b_valid, 1'b0);
    checkOutput("wrBCount", bHs, 1);

    // Read burst, len 3
    bus.req.ar       = '{id: 5'h07, addr: 64'h7000_0000, len: 8'd3, size: 3'd3, burst: 2'b01};
    bus.req.ar_valid = 1'b1;
    bus.req.r_ready  = 1'b1;
    pushRead(5'h07, 3);
    rStart = rHs;
    tick();
    bus.req.ar_valid = 1'b0;
    checkOutput("rdArReadyLow", bus.resp.ar_ready, 1'b0);
    checkOutput("rdRValid", bus.resp.r_valid, 1'b1);
    checkOutput("rdErrAddr", errAddr, 64'h7000_0000);
    checkOutput("rdErrIsWr", errIsWr, 1'b0);
    checkOutput("rdErrCnt", errCnt, 3'd2);
    repeat (3) begin
      tick();
      checkOutput("rdBurstArReady", bus.resp.ar_ready, 1'b0);
      checkOutput("rdBurstRValid", bus.resp.r_valid, 1'b1);
    end
    tick();
    checkOutput("rdArReadyBack", bus.resp.ar_ready, 1'b1);
    checkOutput("rdRDone", bus.resp.r_valid, 1'b0);
    checkOutput("rdBeatCount", rHs - rStart, 4);
    checkOutput("rdQueueEmpty", expR.size(), 0);

    // Backpressured len-255 read
    bus.req.ar       = '{id: 5'h1F, addr: 64'hFFFF_0000_0000_0000, len: 8'd255, size: 3'd0, burst: 2'b00};
    bus.req.ar_valid = 1'b1;
    pushRead(5'h1F, 255);
    rStart = rHs;
    tick();
    bus.req.ar_valid = 1'b0;
    for (int i = 0; i < 4000 && bus.resp.r_valid; i++) begin
      bus.req.r_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checkOutput("bpReadDone", bus.resp.r_valid, 1'b0);
    checkOutput("bpBeatCount", rHs - rStart, 256);
    checkOutput("bpQueueEmpty", expR.size(), 0);
    checkOutput("bpErrCnt", errCnt, 3'd3);
    bus.req.r_ready = 1'b1;

    // B held off for 10 cycles
    bus.req.aw       = '{id: 5'h02, addr: 64'h6000_1000, len: 8'd0, size: 3'd3, burst: 2'b01, atop: 6'd0};
    bus.req.aw_valid = 1'b1;
    bus.req.b_ready  = 1'b0;
    expB.push_back('{id: 5'h02, resp: 2'b11});
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.w_valid  = 1'b1;
    tick();
    bus.req.w_valid  = 1'b0;
    checkOutput("bStallErrCnt", errCnt, 3'd4);
    repeat (10) begin
      checkOutput("bStallValid", bus.resp.b_valid, 1'b1);
      checkOutput("bStallAwReady", bus.resp.aw_ready, 1'b0);
      tick();
    end
    bus.req.b_ready = 1'b1;
    tick();
    checkOutput("bStallAwReadyBack", bus.resp.aw_ready, 1'b1);
    checkOutput("bStallQueueEmpty", expB.size(), 0);

    // Simultaneous AW and AR
    bus.req.aw       = '{id: 5'h04, addr: 64'h6000_2000, len: 8'd0, size: 3'd3, burst: 2'b01, atop: 6'd0};
    bus.req.ar       = '{id: 5'h05, addr: 64'h0001_0000_0000_0000, len: 8'd1, size: 3'd3, burst: 2'b01};
    bus.req.aw_valid = 1'b1;
    bus.req.ar_valid = 1'b1;
    expB.push_back('{id: 5'h04, resp: 2'b11});
    pushRead(5'h05, 1);
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.ar_valid = 1'b0;
    checkOutput("ccErrCnt", errCnt, 3'd6);
    checkOutput("ccErrAddr", errAddr, 64'h0001_0000_0000_0000);
    checkOutput("ccErrIsWr", errIsWr, 1'b0);
    checkOutput("ccWReady", bus.resp.w_ready, 1'b1);
    checkOutput("ccRValid", bus.resp.r_valid, 1'b1);
    bus.req.w_valid = 1'b1;
    tick();
    bus.req.w_valid = 1'b0;
    checkOutput("ccBValid", bus.resp.b_valid, 1'b1);
    checkOutput("ccRValid2", bus.resp.r_valid, 1'b1);
    tick();
    checkOutput("ccAwReady", bus.resp.aw_ready, 1'b1);
    checkOutput("ccArReady", bus.resp.ar_ready, 1'b1);
    checkOutput("ccQueuesEmpty", expB.size() + expR.size(), 0);

    // W presented well before AW
    bus.req.w       = '{data: 64'h5555, strb: 8'hFF, last: 1'b1};
    bus.req.w_valid = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("ordWReadyEarly", bus.resp.w_ready, 1'b0);
    end
    bus.req.aw       = '{id: 5'h06, addr: 64'h6000_3000, len: 8'd0, size: 3'd3, burst: 2'b01, atop: 6'd0};
    bus.req.aw_valid = 1'b1;
    expB.push_back('{id: 5'h06, resp: 2'b11});
    tick();
    bus.req.aw_valid = 1'b0;
    checkOutput("ordWReady", bus.resp.w_ready, 1'b1);
    checkOutput("ordErrCnt", errCnt, 3'd7);
    tick();
    bus.req.w_valid = 1'b0;
    checkOutput("ordBValid", bus.resp.b_valid, 1'b1);
    tick();
    checkOutput("ordAwReady", bus.resp.aw_ready, 1'b1);
    checkOutput("ordQueueEmpty", expB.size(), 0);

    // Counter saturation with a double handshake at all-ones
    bus.req.aw       = '{id: 5'h08, addr: 64'h6000_4000, len: 8'd0, size: 3'd3, burst: 2'b01, atop: 6'd0};
    bus.req.ar       = '{id: 5'h09, addr: 64'h9000_0000, len: 8'd0, size: 3'd3, burst: 2'b01};
    bus.req.aw_valid = 1'b1;
    bus.req.ar_valid = 1'b1;
    expB.push_back('{id: 5'h08, resp: 2'b11});
    pushRead(5'h09, 0);
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.ar_valid = 1'b0;
    checkOutput("satErrCnt", errCnt, 3'd7);
    checkOutput("satErrAddr", errAddr, 64'h9000_0000);
    bus.req.w_valid = 1'b1;
    tick();
    bus.req.w_valid = 1'b0;
    checkOutput("satRDone", bus.resp.r_valid, 1'b0);
    tick();
    checkOutput("satAwReady", bus.resp.aw_ready, 1'b1);
    checkOutput("satQueuesEmpty", expB.size() + expR.size(), 0);

    // Reset during beat 2 of a len-7 read
    bus.req.ar       = '{id: 5'h0A, addr: 64'hA000_0000, len: 8'd7, size: 3'd3, burst: 2'b01};
    bus.req.ar_valid = 1'b1;
    expR.push_back('{id: 5'h0A, data: ExpData, resp: 2'b11, last: 1'b0});
    tick();
    bus.req.ar_valid = 1'b0;
    tick();
    checkOutput("rstMidBeat2Valid", bus.resp.r_valid, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("rstMidRValid", bus.resp.r_valid, 1'b0);
    checkOutput("rstMidArReady", bus.resp.ar_ready, 1'b1);
    checkOutput("rstMidErrCnt", errCnt, '0);
    checkOutput("rstMidQueueEmpty", expR.size(), 0);
    rst = 1'b0;
    tick();
    bus.req.ar       = '{id: 5'h0B, addr: 64'hB000_0000, len: 8'd7, size: 3'd3, burst: 2'b01};
    bus.req.ar_valid = 1'b1;
    pushRead(5'h0B, 7);
    rStart = rHs;
    tick();
    bus.req.ar_valid = 1'b0;
    waitReadDone(20);
    checkOutput("postRstBeatCount", rHs - rStart, 8);
    checkOutput("postRstQueueEmpty", expR.size(), 0);
    checkOutput("postRstErrCnt", errCnt, 3'd1);
    checkOutput("postRstErrAddr", errAddr, 64'hB000_0000);

    applyStimulus();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_decerr_slv.md
# axi_decerr_slv

AXI4 error slave on the default (unmapped) port of the SoC crossbar. Any access outside the defined peripheral windows lands here: Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, NewDev and DRAM. Examples are the hole between NewDevBase+NewDevLength and DRAMBase, and the hole above DRAMBase+DRAMLength. The slave completes every such burst protocol-correctly with DECERR and logs the most recent offending address for debug.

## Interface
- `RespData`, default 64'hCA11_AB1E_BADC_AB1E: value driven on every R beat.
- `CntWidth`, default 32: width of the error counter.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `axi_req_i` in, `ariane_axi::req_slv_t`: AW/W/AR channels plus `b_ready`/`r_ready`; ID width IdWidthSlave (5).
- `axi_resp_o` out, `ariane_axi::resp_slv_t`: AW/W/AR ready, B and R channels.
- `err_addr_o` out, 64: address of the last accepted AW or AR.
- `err_is_wr_o` out, 1: 1 if that last access was a write.
- `err_cnt_o` out, CntWidth: number of accepted AW plus AR. Saturates at all-ones.

## Operation
- The write FSM and the read FSM are fully independent. Each channel has at most one transaction outstanding.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: `aw_ready`=1. On AW handshake, capture `aw.id` and go to W_DATA.
  - W_DATA: `w_ready`=1. Beats are discarded. A W handshake with `w.last`=1 moves to W_RESP. Beat count is not checked against `aw.len`; only `w.last` ends the burst.
  - W_RESP: `b_valid`=1, `b.id`=captured ID, `b.resp`=DECERR (2'b11). On `b_ready`, go to W_IDLE.
  - W data arriving before AW is not accepted: `w_ready`=0 outside W_DATA.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: `ar_ready`=1. On AR handshake, capture `ar.id` and load the 8-bit beat counter with `ar.len`. Go to R_DATA.
  - R_DATA: `r_valid`=1, `r.data`=RespData, `r.resp`=DECERR, `r.id`=captured ID, `r.last`=(counter==0).
  - On an R handshake: if counter==0, go to R_IDLE; else decrement the counter.
  - `ar.len`=255 produces 256 beats. `ar.size`, `ar.burst` and `ar.addr` do not affect the beat count.
- `aw.atop` is ignored. Atomics complete with B only; the crossbar rule set routes no atomics to this port.
- Error log:
  - `err_cnt_o` increments by the number of AW and AR handshakes in that cycle (0, 1 or 2). It saturates and does not wrap.
  - On a simultaneous AW and AR handshake, the AR address and `err_is_wr_o`=0 win.
- Valid/data outputs hold stable while valid and not ready, per AXI.
- Reset mid-burst: both FSMs return to IDLE immediately and the captured state is lost. The master is reset in the same domain.

## Timing
- Reset values:
  - FSMs in W_IDLE and R_IDLE.
  - `aw_ready`=1 and `ar_ready`=1 (pure state decode).
  - `w_ready`=0, `b_valid`=0, `r_valid`=0.
  - `b`/`r` payload = 0.
  - `err_addr_o`=0, `err_is_wr_o`=0, `err_cnt_o`=0.
- All readies and valids are decoded from registered state only. There is no combinational path from any input valid to an output ready.
- AW handshake in cycle n: `w_ready`=1 from cycle n+1.
- Last W handshake in cycle n: `b_valid`=1 in cycle n+1.
- B handshake in cycle n: `aw_ready`=1 in cycle n+1. A single-beat write therefore occupies a minimum of 3 cycles.
- AR handshake in cycle n: first R beat valid in cycle n+1. With `r_ready`=1 held, one beat per cycle; `ar_ready` returns in the cycle after the `r.last` handshake.
- Log outputs update in the cycle after the handshake.

## Structure
- Add `ErrSlvRespData` (64'hCA11_AB1E_BADC_AB1E) to the `ariane_soc` package. The top passes it to `RespData`.
- Use `axi_pkg::RESP_DECERR` for response codes.
- FSM state enums are local to the module.
- One sub-module is natural: `axi_decerr_rd`, the read-burst generator (AR capture, beat counter, R drive). The write FSM and the logging stay in the top module.

## Test plan
- Single write: AW addr 64'h6000_0000, id 5'h13, len 0; one W with last; `b_ready`=1 → B id 5'h13, resp 2'b11, 3 cycles after AW. `err_addr_o`=64'h6000_0000, `err_is_wr_o`=1, `err_cnt_o`=1.
- Read burst: AR id 5'h07, len 3, `r_ready`=1 → 4 beats on consecutive cycles, each data 64'hCA11_AB1E_BADC_AB1E, resp 2'b11, id 5'h07; `last` only on beat 4. `ar_ready` deasserted during the burst.
- Backpressure: len 255 read with `r_ready` toggled randomly → exactly 256 handshakes; payload stable while stalled. B held with `b_ready`=0 for 10 cycles → `b_valid` stays 1 and `aw_ready` stays 0.
- Concurrency: AW and AR handshake in the same cycle → both complete independently; `err_cnt_o` +2; `err_addr_o`=AR address, `err_is_wr_o`=0.
- Ordering: W presented 5 cycles before AW → `w_ready`=0 until the cycle after the AW handshake, then the burst completes normally.
- Reset mid-burst: assert `rst_i` during beat 2 of a len-7 read → next cycle `r_valid`=0, `ar_ready`=1, `err_cnt_o`=0. A subsequent AR returns the full len+1 beats.
